// File: rtl/dac_driver_pkg.sv
// dac_driver_pkg: shared definitions for the dac_driver_sync slice.
//   - drv_state_e    : power sequencing FSM states
//   - PARK_*_BIT     : per-bit value of the parked data / complement drives
//   - count_to_therm : ones count -> thermometer code (ones from bit 0)
package dac_driver_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    WAKE   = 2'd1,
    ACTIVE = 2'd2,
    DRAIN  = 2'd3
  } drv_state_e;

  localparam logic PARK_DATA_BIT = 1'b0;
  localparam logic PARK_COMP_BIT = 1'b1;

  // Widest thermometer segment the helper can build; callers truncate.
  localparam int unsigned THERM_MAX = 64;

  function automatic logic [THERM_MAX-1:0] count_to_therm(input int unsigned cnt);
    logic [THERM_MAX-1:0] res;
    for (int unsigned i = 0; i < THERM_MAX; i++) begin
      res[i] = (i < cnt);
    end
    return res;
  endfunction

endpackage

// File: rtl/dac_driver_sync_therm_repair.sv
// therm_repair: combinational thermometer bubble repair.
//   therm_in  : raw thermometer code (ones expected from bit 0 upward)
//   therm_out : repaired code, count ones from bit 0 (or from ptr, wrapping,
//               when DRIVER_DWA_EN is defined)
//   bubble    : therm_in differs from its repaired (unrotated) form
//   ptr/count : DRIVER_DWA_EN only - rotation start and ones count
module therm_repair #(
  parameter int unsigned NTHERM = 17,
`ifdef DRIVER_DWA_EN
  parameter int unsigned PTR_W  = $clog2(NTHERM),
`endif
  parameter int unsigned CNT_W  = $clog2(NTHERM + 1)
) (
  input  logic [NTHERM-1:0] therm_in,
`ifdef DRIVER_DWA_EN
  input  logic [PTR_W-1:0]  ptr,
  output logic [CNT_W-1:0]  count,
`endif
  output logic [NTHERM-1:0] therm_out,
  output logic              bubble
);
  import dac_driver_pkg::*;

  logic [CNT_W-1:0]  cnt;
  logic [NTHERM-1:0] direct;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NTHERM; i++) begin
      cnt = cnt + CNT_W'(therm_in[i]);
    end
  end

  assign direct = NTHERM'(count_to_therm(32'(cnt)));
  // Detection always compares against the unrotated code.
  assign bubble = (therm_in != direct);

`ifdef DRIVER_DWA_EN
  logic [2*NTHERM-1:0] dbl;

  assign count = cnt;
  // Rotate left by ptr modulo NTHERM: shift into a double-width word and
  // fold the overflow half back onto the low half.
  assign dbl       = {{NTHERM{1'b0}}, direct} << ptr;
  assign therm_out = dbl[NTHERM-1:0] | dbl[2*NTHERM-1:NTHERM];
`else
  assign therm_out = direct;
`endif

endmodule

// File: rtl/dac_driver_sync.sv
// dac_driver_sync: clocked segmented DAC driver.
// Re-times binary and thermometer segment codes through PIPE_DEPTH register
// stages, generates registered complement drives, repairs thermometer
// bubbles and sequences power-up/down with an OFF/WAKE/ACTIVE/DRAIN FSM.
// Optional: define DRIVER_DWA_EN for data-weighted averaging on the
// thermometer segment (rotating start pointer).
// Ports:
//   clk, rst (sync, active-high)
//   datain / datatherm          : binary / thermometer segment inputs
//   pdb, supply_ok              : enable and supply-good
//   databinout(b)               : re-timed binary drive and complement
//   datathermout(b)             : re-timed repaired thermo drive and complement
//   ready                       : outputs carry live data
//   bubble_err, bubble_cnt      : repair pulse and saturating repair count
//
// state  | meaning
// OFF    | parked, waiting for pdb & supply_ok
// WAKE   | settle timer running, still parked
// ACTIVE | repaired input loaded into the pipeline every cycle
// DRAIN  | park code injected for PIPE_DEPTH cycles, then OFF
module dac_driver_sync #(
  parameter int unsigned NBIN        = 7,
  parameter int unsigned NTHERM      = 17,
  parameter int unsigned PIPE_DEPTH  = 2,
  parameter int unsigned WAKE_CYCLES = 8,
  parameter int unsigned ERRCNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NBIN-1:0]     datain,
  input  logic [NTHERM-1:0]   datatherm,
  input  logic                pdb,
  input  logic                supply_ok,
  output logic [NBIN-1:0]     databinout,
  output logic [NBIN-1:0]     databinoutb,
  output logic [NTHERM-1:0]   datathermout,
  output logic [NTHERM-1:0]   datathermoutb,
  output logic                ready,
  output logic                bubble_err,
  output logic [ERRCNT_W-1:0] bubble_cnt
);
  import dac_driver_pkg::*;

  localparam int unsigned LAST  = PIPE_DEPTH - 1;
  localparam int unsigned TMR_W = 8;

  drv_state_e       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             live;

  logic [NBIN-1:0]   bin_q    [PIPE_DEPTH];
  logic [NBIN-1:0]   bin_d    [PIPE_DEPTH];
  logic [NBIN-1:0]   binb_q   [PIPE_DEPTH];
  logic [NBIN-1:0]   binb_d   [PIPE_DEPTH];
  logic [NTHERM-1:0] therm_q  [PIPE_DEPTH];
  logic [NTHERM-1:0] therm_d  [PIPE_DEPTH];
  logic [NTHERM-1:0] thermb_q [PIPE_DEPTH];
  logic [NTHERM-1:0] thermb_d [PIPE_DEPTH];
  logic              err_q    [PIPE_DEPTH];
  logic              err_d    [PIPE_DEPTH];
  logic              vld_q    [PIPE_DEPTH];
  logic              vld_d    [PIPE_DEPTH];

  logic [ERRCNT_W-1:0] cnt_q, cnt_d;
  logic [NTHERM-1:0]   therm_fix;
  logic                bubble;

`ifdef DRIVER_DWA_EN
  localparam int unsigned PTR_W = $clog2(NTHERM);
  localparam int unsigned CNT_W = $clog2(NTHERM + 1);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] rep_count;
  logic [CNT_W-1:0] ptr_adv;
  logic [PTR_W:0]   ptr_sum;
`endif

  therm_repair #(
    .NTHERM (NTHERM)
  ) u_repair (
    .therm_in  (datatherm),
`ifdef DRIVER_DWA_EN
    .ptr       (ptr_q),
    .count     (rep_count),
`endif
    .therm_out (therm_fix),
    .bubble    (bubble)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // FSM: next state. One down-counter serves both WAKE and DRAIN; it is
  // loaded with (length-1) on entry and the state exits at zero.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      OFF: begin
        if (supply_ok && pdb) begin
          state_d = WAKE;
          tmr_d   = TMR_W'(WAKE_CYCLES - 1);
        end
      end
      WAKE: begin
        if (!supply_ok || !pdb) begin
          state_d = OFF;
        end else if (tmr_q == '0) begin
          state_d = ACTIVE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ACTIVE: begin
        if (!supply_ok || !pdb) begin
          state_d = DRAIN;
          tmr_d   = TMR_W'(PIPE_DEPTH - 1);
        end
      end
      DRAIN: begin
        // pdb is deliberately ignored here; only a supply drop cuts it short.
        if (!supply_ok || tmr_q == '0) begin
          state_d = OFF;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = OFF;
    endcase
  end

  // FSM: outputs
  always_comb begin
    live = (state_q == ACTIVE);
  end

  // Pipeline: stage 0 takes the repaired input in ACTIVE, park code
  // otherwise. ready travels with the data so it marks exactly the live
  // samples at the outputs.
  always_comb begin
    bin_d[0]    = live ? datain : {NBIN{PARK_DATA_BIT}};
    therm_d[0]  = live ? therm_fix : {NTHERM{PARK_DATA_BIT}};
    binb_d[0]   = ~bin_d[0];
    thermb_d[0] = ~therm_d[0];
    err_d[0]    = live && bubble;
    vld_d[0]    = live;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      bin_d[i]    = bin_q[i-1];
      binb_d[i]   = binb_q[i-1];
      therm_d[i]  = therm_q[i-1];
      thermb_d[i] = thermb_q[i-1];
      err_d[i]    = err_q[i-1];
      vld_d[i]    = vld_q[i-1];
    end
  end

  // Count updates on the same edge the error flag reaches the outputs.
  always_comb begin
    cnt_d = cnt_q;
    if (err_d[LAST] && (cnt_q != '1)) begin
      cnt_d = cnt_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        bin_q[i]    <= {NBIN{PARK_DATA_BIT}};
        binb_q[i]   <= {NBIN{PARK_COMP_BIT}};
        therm_q[i]  <= {NTHERM{PARK_DATA_BIT}};
        thermb_q[i] <= {NTHERM{PARK_COMP_BIT}};
        err_q[i]    <= 1'b0;
        vld_q[i]    <= 1'b0;
      end
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        bin_q[i]    <= bin_d[i];
        binb_q[i]   <= binb_d[i];
        therm_q[i]  <= therm_d[i];
        thermb_q[i] <= thermb_d[i];
        err_q[i]    <= err_d[i];
        vld_q[i]    <= vld_d[i];
      end
      cnt_q <= cnt_d;
    end
  end

`ifdef DRIVER_DWA_EN
  // A full-scale count (NTHERM ones) advances the pointer by zero.
  always_comb begin
    ptr_adv = (rep_count == CNT_W'(NTHERM)) ? '0 : rep_count;
    ptr_sum = (PTR_W+1)'(ptr_q) + (PTR_W+1)'(ptr_adv);
    if (ptr_sum >= (PTR_W+1)'(NTHERM)) begin
      ptr_sum = ptr_sum - (PTR_W+1)'(NTHERM);
    end
    ptr_d = ptr_q;
    if (state_q == OFF) begin
      ptr_d = '0;
    end else if (live) begin
      ptr_d = ptr_sum[PTR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign databinout    = bin_q[LAST];
  assign databinoutb   = binb_q[LAST];
  assign datathermout  = therm_q[LAST];
  assign datathermoutb = thermb_q[LAST];
  assign ready         = vld_q[LAST];
  assign bubble_err    = err_q[LAST];
  assign bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_dac_driver_sync.sv
// tb_dac_driver_sync: self-checking bench for dac_driver_sync (default
// parameters). Live samples push expectations into a queue; a negedge
// monitor pops one per ready cycle and checks parked outputs otherwise.
// Build with DRIVER_DWA_EN defined to exercise the rotation mode.
module tb_dac_driver_sync;
  localparam int NBIN        = 7;
  localparam int NTHERM      = 17;
  localparam int PIPE_DEPTH  = 2;
  localparam int WAKE_CYCLES = 8;
  localparam int ERRCNT_W    = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [NBIN-1:0]     datain;
  logic [NTHERM-1:0]   datatherm;
  logic                pdb;
  logic                supply_ok;
  logic [NBIN-1:0]     databinout;
  logic [NBIN-1:0]     databinoutb;
  logic [NTHERM-1:0]   datathermout;
  logic [NTHERM-1:0]   datathermoutb;
  logic                ready;
  logic                bubble_err;
  logic [ERRCNT_W-1:0] bubble_cnt;

  dac_driver_sync dut (
    .clk           (clk),
    .rst           (rst),
    .datain        (datain),
    .datatherm     (datatherm),
    .pdb           (pdb),
    .supply_ok     (supply_ok),
    .databinout    (databinout),
    .databinoutb   (databinoutb),
    .datathermout  (datathermout),
    .datathermoutb (datathermoutb),
    .ready         (ready),
    .bubble_err    (bubble_err),
    .bubble_cnt    (bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NBIN-1:0]   bin;
    logic [NTHERM-1:0] therm;
    logic [NTHERM-1:0] exp_therm;
    logic              exp_err;
  } vec_t;

  typedef struct {
    logic [NBIN-1:0]   bin;
    logic [NBIN-1:0]   binb;
    logic [NTHERM-1:0] therm;
    logic [NTHERM-1:0] thermb;
    logic              err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rise_cyc = -1;
  int   fall_cyc = -1;
  int   cnt_m = 0;
  int   ptr_m = 0;
  bit   mon_en = 1'b0;
  logic ready_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

`ifdef DRIVER_DWA_EN
  function automatic logic [NTHERM-1:0] rot(input logic [NTHERM-1:0] b, input int p);
    logic [2*NTHERM-1:0] d;
    d = {{NTHERM{1'b0}}, b} << p;
    return d[NTHERM-1:0] | d[2*NTHERM-1:NTHERM];
  endfunction
`endif

  // Drive one cycle of inputs just after the edge; live marks a cycle the
  // FSM spends in ACTIVE, whose sample must appear PIPE_DEPTH cycles later.
  task automatic drive(input logic [NBIN-1:0] b, input logic [NTHERM-1:0] t,
                       input logic [NTHERM-1:0] exp_direct, input bit e,
                       input bit live, input bit p, input bit s);
    @(posedge clk);
    #1;
    datain    = b;
    datatherm = t;
    pdb       = p;
    supply_ok = s;
    if (live) begin
      exp_t x;
      x.bin  = b;
      x.binb = ~b;
      x.err  = e;
`ifdef DRIVER_DWA_EN
      x.therm = rot(exp_direct, ptr_m);
      ptr_m   = (ptr_m + ($countones(exp_direct) % NTHERM)) % NTHERM;
`else
      x.therm = exp_direct;
`endif
      x.thermb = ~x.therm;
      sb.push_back(x);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (mon_en) begin
      if (ready && !ready_prev && rise_cyc < 0) rise_cyc = cyc;
      if (!ready && ready_prev) fall_cyc = cyc;
      ready_prev = ready;
      if (ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_live: ready=1 but no sample pending (cycle %0d)", cyc);
        end else begin
          x = sb.pop_front();
          if (x.err && cnt_m < 255) cnt_m++;
          check("databinout", 32'(databinout), 32'(x.bin));
          check("databinoutb", 32'(databinoutb), 32'(x.binb));
          check("datathermout", 32'(datathermout), 32'(x.therm));
          check("datathermoutb", 32'(datathermoutb), 32'(x.thermb));
          check("bubble_err", 32'(bubble_err), 32'(x.err));
        end
      end else begin
        check("park_bin", 32'(databinout), 32'h0);
        check("park_binb", 32'(databinoutb), 32'h7F);
        check("park_therm", 32'(datathermout), 32'h0);
        check("park_thermb", 32'(datathermoutb), 32'h1FFFF);
        check("park_err", 32'(bubble_err), 32'h0);
      end
      check("bubble_cnt", 32'(bubble_cnt), 32'(cnt_m));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int   c0, c_dn, c_off;

    vecs[0] = '{7'h55, 17'h000FF, 17'h000FF, 1'b0};
    vecs[1] = '{7'h00, 17'h00000, 17'h00000, 1'b0};
    vecs[2] = '{7'h7F, 17'h1FFFF, 17'h1FFFF, 1'b0};
    vecs[3] = '{7'h2A, 17'h0000B, 17'h00007, 1'b1};
    vecs[4] = '{7'h01, 17'h10000, 17'h00001, 1'b1};
    vecs[5] = '{7'h40, 17'h0AAAA, 17'h000FF, 1'b1};
    vecs[6] = '{7'h33, 17'h00001, 17'h00001, 1'b0};
    vecs[7] = '{7'h12, 17'h0FFFF, 17'h0FFFF, 1'b0};

    rst       = 1'b1;
    pdb       = 1'b1;
    supply_ok = 1'b1;
    datain    = 7'h7F;
    datatherm = 17'h1FFFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bin", 32'(databinout), 32'h0);
    check("rst_binb", 32'(databinoutb), 32'h7F);
    check("rst_therm", 32'(datathermout), 32'h0);
    check("rst_thermb", 32'(datathermoutb), 32'h1FFFF);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_err", 32'(bubble_err), 32'h0);
    check("rst_cnt", 32'(bubble_cnt), 32'h0);

    @(posedge clk);
    #1;
    rst    = 1'b0;
    c0     = cyc;
    mon_en = 1'b1;

    // WAKE: inputs carry junk that must never reach the outputs.
    for (int k = 0; k < WAKE_CYCLES; k++) drive(7'h7F, 17'h1FFFF, '0, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) drive(vecs[i].bin, vecs[i].therm, vecs[i].exp_therm, vecs[i].exp_err, 1, 1, 1);
    check("ready_rise", 32'(rise_cyc - c0), 32'(1 + WAKE_CYCLES + PIPE_DEPTH));

    for (int i = 0; i < 300; i++) drive(7'h2A, 17'h0000B, 17'h00007, 1, 1, 1, 1);

    // Power-down: last live sample, two DRAIN cycles with re-enable
    // attempted, then hold pdb low in OFF.
    drive(7'h11, 17'h00003, 17'h00003, 0, 1, 0, 1);
    c_dn = cyc;
    drive(7'h22, 17'h1FFFF, '0, 0, 0, 1, 1);
    drive(7'h22, 17'h1FFFF, '0, 0, 0, 1, 1);
    drive(7'h33, 17'h0000F, '0, 0, 0, 0, 1);
    for (int k = 0; k < 6; k++) drive(7'h44, 17'h000FF, '0, 0, 0, 0, 1);
    check("ready_fall", 32'(fall_cyc - c_dn), 32'(1 + PIPE_DEPTH));
    check("cnt_saturated", 32'(bubble_cnt), 32'd255);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);

    // Supply drop in the 4th WAKE cycle, then a full restart.
    drive(7'h01, 17'h00001, '0, 0, 0, 1, 1);
    for (int k = 0; k < 3; k++) drive(7'h01, 17'h00001, '0, 0, 0, 1, 1);
    drive(7'h01, 17'h00001, '0, 0, 0, 1, 0);
    rise_cyc = -1;
    drive(7'h01, 17'h00001, '0, 0, 0, 1, 1);
    c_off = cyc;
    ptr_m = 0;
    for (int k = 0; k < WAKE_CYCLES; k++) drive(7'h01, 17'h00001, '0, 0, 0, 1, 1);
    // Four identical 5-ones samples: direct mapping repeats bits 0-4; with
    // rotation they land on 0-4, 5-9, 10-14, then 15,16,0,1,2.
    for (int k = 0; k < 4; k++) drive(7'h05, 17'h0001F, 17'h0001F, 0, 1, 1, 1);
    drive(7'h06, 17'h00007, 17'h00007, 0, 1, 0, 1);
    for (int k = 0; k < 6; k++) drive(7'h00, 17'h00000, '0, 0, 0, 0, 1);
    check("restart_ready_rise", 32'(rise_cyc - c_off), 32'(1 + WAKE_CYCLES + PIPE_DEPTH));
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
